// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg
//   Shared types and byte constants for the USB full-speed TX sequencer.
//   pid_e      : request PID codes as presented on tx_pid (5..7 illegal)
//   state_e    : sequencer FSM states
//   pid_byte() : maps a PID code to the on-wire PID byte (PID plus its
//                check nibble)
package usb_tx_pkg;

  typedef enum logic [2:0] {
    PID_ACK   = 3'd0,
    PID_NAK   = 3'd1,
    PID_STALL = 3'd2,
    PID_DATA0 = 3'd3,
    PID_DATA1 = 3'd4
  } pid_e;

  localparam logic [7:0] SYNC_BYTE  = 8'h80;
  localparam logic [7:0] ACK_BYTE   = 8'hD2;
  localparam logic [7:0] NAK_BYTE   = 8'h5A;
  localparam logic [7:0] STALL_BYTE = 8'h1E;
  localparam logic [7:0] DATA0_BYTE = 8'hC3;
  localparam logic [7:0] DATA1_BYTE = 8'h4B;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    LOAD_SYNC   = 4'd1,
    SEND_SYNC   = 4'd2,
    LOAD_PID    = 4'd3,
    SEND_PID    = 4'd4,
    LOAD_DATA   = 4'd5,
    SEND_DATA   = 4'd6,
    LOAD_CRC_LO = 4'd7,
    SEND_CRC_LO = 4'd8,
    LOAD_CRC_HI = 4'd9,
    SEND_CRC_HI = 4'd10,
    EOP         = 4'd11,
    IDLE_J      = 4'd12,
    DONE        = 4'd13
  } state_e;

  function automatic logic [7:0] pid_byte(input logic [2:0] pid);
    logic [7:0] b;
    case (pid)
      PID_ACK:   b = ACK_BYTE;
      PID_NAK:   b = NAK_BYTE;
      PID_STALL: b = STALL_BYTE;
      PID_DATA0: b = DATA0_BYTE;
      PID_DATA1: b = DATA1_BYTE;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// usb_bit_timer
//   Counts clk cycles within one USB bit time and flags the last cycle.
//   clk, n_rst : clock, asynchronous active-low reset
//   clear      : synchronous return of the count to 0 (dominates enable)
//   enable     : advance the count this cycle
//   bit_tick   : high on the last cycle of a bit time while enabled; the
//                count wraps to 0 on that same edge
module usb_bit_timer #(
  parameter int BIT_CYCLES = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign bit_tick = enable && (cnt == CNT_W'(BIT_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer
//   Sequences one USB full-speed packet: SYNC, PID, optional payload and
//   CRC16, then EOP (2 bit times of SE0) and 1 bit time of idle J.
//   clk, n_rst  : clock, asynchronous active-low reset
//   tx_req      : start request (only looked at in IDLE)
//   tx_pid      : 0=ACK 1=NAK 2=STALL 3=DATA0 4=DATA1, others dropped
//   tx_len      : payload length for data PIDs, clamped to MAX_PAYLOAD
//   fifo_data   : show-ahead FIFO head
//   crc16       : final CRC16 from the external CRC unit
//   byte_done   : shifter has finished the last loaded byte
//   byte_out    : byte for the shifter (LSB first on the wire)
//   byte_load   : byte_out is valid, shifter takes it this cycle
//   fifo_rd     : pop the FIFO head
//   crc_clear   : reset the CRC unit
//   crc_enable  : CRC unit absorbs byte_out
//   eop_out     : drive SE0
//   busy        : packet in progress (acceptance+1 through DONE)
//   tx_done     : one-cycle completion pulse
//   state_dbg   : current FSM state encoding
//
// Shifter handshake: byte_load is a one-cycle "valid" with byte_out; the
// shifter is assumed ready whenever we are in a LOAD state because we only
// load after its byte_done "ready" pulse for the previous byte. byte_done is
// honoured only in SEND states and ignored everywhere else.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int BIT_CYCLES  = 8,
  localparam int LEN_W      = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tx_req,
  input  logic [2:0]       tx_pid,
  input  logic [LEN_W-1:0] tx_len,
  input  logic [7:0]       fifo_data,
  input  logic [15:0]      crc16,
  input  logic             byte_done,
  output logic [7:0]       byte_out,
  output logic             byte_load,
  output logic             fifo_rd,
  output logic             crc_clear,
  output logic             crc_enable,
  output logic             eop_out,
  output logic             busy,
  output logic             tx_done,
  output logic [3:0]       state_dbg
);

  state_e           state, state_nxt;
  logic [2:0]       pid_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             eop_half;
  logic             timer_en;
  logic             bit_tick;
  logic             is_data;
  logic             req_ok;
  logic [LEN_W-1:0] len_clamp;

  assign is_data   = (pid_q == PID_DATA0) || (pid_q == PID_DATA1);
  assign req_ok    = tx_req && (tx_pid <= PID_DATA1);
  assign len_clamp = (tx_len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : tx_len;
  assign timer_en  = (state == EOP) || (state == IDLE_J);
  assign state_dbg = state;

  // Timer is held cleared outside EOP/IDLE_J so each phase starts from a
  // fresh bit boundary; the wrap at the end of EOP hands IDLE_J a zero count.
  usb_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (!timer_en),
    .enable  (timer_en),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pid_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      eop_half <= 1'b0;
    end else begin
      if (state == IDLE && req_ok) begin
        pid_q <= tx_pid;
        len_q <= len_clamp;
      end
      // Counter is armed while the PID goes out, so SEND_PID can branch on it.
      if (state == LOAD_PID) begin
        cnt_q <= len_q;
      end else if (state == LOAD_DATA) begin
        cnt_q <= cnt_q - LEN_W'(1);
      end
      // EOP is two bit times: first tick marks the halfway point.
      if (state != EOP) begin
        eop_half <= 1'b0;
      end else if (bit_tick) begin
        eop_half <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_out   = 8'h00;
    byte_load  = 1'b0;
    fifo_rd    = 1'b0;
    crc_clear  = 1'b0;
    crc_enable = 1'b0;
    eop_out    = 1'b0;
    tx_done    = 1'b0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (req_ok) state_nxt = LOAD_SYNC;
      end
      LOAD_SYNC: begin
        byte_out  = SYNC_BYTE;
        byte_load = 1'b1;
        state_nxt = SEND_SYNC;
      end
      SEND_SYNC: begin
        if (byte_done) state_nxt = LOAD_PID;
      end
      LOAD_PID: begin
        byte_out  = pid_byte(pid_q);
        byte_load = 1'b1;
        crc_clear = is_data;
        state_nxt = SEND_PID;
      end
      SEND_PID: begin
        if (byte_done) begin
          if (!is_data)          state_nxt = EOP;
          else if (cnt_q != '0)  state_nxt = LOAD_DATA;
          else                   state_nxt = LOAD_CRC_LO;
        end
      end
      LOAD_DATA: begin
        byte_out   = fifo_data;
        byte_load  = 1'b1;
        fifo_rd    = 1'b1;
        crc_enable = 1'b1;
        state_nxt  = SEND_DATA;
      end
      SEND_DATA: begin
        if (byte_done) state_nxt = (cnt_q != '0) ? LOAD_DATA : LOAD_CRC_LO;
      end
      LOAD_CRC_LO: begin
        byte_out  = crc16[7:0];
        byte_load = 1'b1;
        state_nxt = SEND_CRC_LO;
      end
      SEND_CRC_LO: begin
        if (byte_done) state_nxt = LOAD_CRC_HI;
      end
      LOAD_CRC_HI: begin
        byte_out  = crc16[15:8];
        byte_load = 1'b1;
        state_nxt = SEND_CRC_HI;
      end
      SEND_CRC_HI: begin
        if (byte_done) state_nxt = EOP;
      end
      EOP: begin
        eop_out = 1'b1;
        if (bit_tick && eop_half) state_nxt = IDLE_J;
      end
      IDLE_J: begin
        if (bit_tick) state_nxt = DONE;
      end
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb_usb_tx_sequencer
//   Directed bench for usb_tx_sequencer (MAX_PAYLOAD=64, BIT_CYCLES=8).
//   A shifter model answers each byte_load with byte_done 8 cycles later;
//   a FIFO model presents fifo_mem[] show-ahead; a negedge monitor records
//   loaded bytes and strobe counts for comparison against exp_q.
module tb_usb_tx_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        tx_req;
  logic [2:0]  tx_pid;
  logic [6:0]  tx_len;
  logic [7:0]  fifo_data;
  logic [15:0] crc16;
  logic        byte_done;
  logic [7:0]  byte_out;
  logic        byte_load;
  logic        fifo_rd;
  logic        crc_clear;
  logic        crc_enable;
  logic        eop_out;
  logic        busy;
  logic        tx_done;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] fifo_mem[0:127];

  int rd_idx, rd_cnt, en_cnt, clr_cnt, done_cnt, eop_cnt, ij_cnt, busy_cnt;
  bit eop_seen;
  int shift_cnt = 0;
  bit stray_en  = 1'b0;

  usb_tx_sequencer #(
    .MAX_PAYLOAD(64),
    .BIT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_req    (tx_req),
    .tx_pid    (tx_pid),
    .tx_len    (tx_len),
    .fifo_data (fifo_data),
    .crc16     (crc16),
    .byte_done (byte_done),
    .byte_out  (byte_out),
    .byte_load (byte_load),
    .fifo_rd   (fifo_rd),
    .crc_clear (crc_clear),
    .crc_enable(crc_enable),
    .eop_out   (eop_out),
    .busy      (busy),
    .tx_done   (tx_done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shifter model ----------------
  initial begin
    byte_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      byte_done = 1'b0;
      if (!n_rst) begin
        shift_cnt = 0;
      end else begin
        if (shift_cnt > 0) begin
          shift_cnt--;
          if (shift_cnt == 0) byte_done = 1'b1;
        end
        if (byte_load) shift_cnt = 8;
        if (stray_en && eop_out) byte_done = 1'b1;
      end
    end
  end

  // ---------------- monitor + FIFO model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (byte_load) got_q.push_back(byte_out);
      if (fifo_rd) begin
        rd_cnt++;
        rd_idx++;
        if (rd_idx < 128) fifo_data = fifo_mem[rd_idx];
      end
      if (crc_enable) en_cnt++;
      if (crc_clear)  clr_cnt++;
      if (busy)       busy_cnt++;
      if (eop_out) begin
        eop_cnt++;
        eop_seen = 1'b1;
      end else if (busy && eop_seen && !tx_done) begin
        ij_cnt++;
      end
      if (tx_done) begin
        done_cnt++;
        eop_seen = 1'b0;
      end
    end
  end

  // ---------------- driver / checking tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats;
    got_q.delete();
    exp_q.delete();
    rd_idx   = 0;
    rd_cnt   = 0;
    en_cnt   = 0;
    clr_cnt  = 0;
    done_cnt = 0;
    eop_cnt  = 0;
    ij_cnt   = 0;
    busy_cnt = 0;
    eop_seen = 1'b0;
    fifo_data = fifo_mem[0];
  endtask

  task automatic send(input logic [2:0] pid, input logic [6:0] len, input bit hold);
    check("idle_before_req", busy, 0);
    tx_pid = pid;
    tx_len = len;
    tx_req = 1'b1;
    tick;
    check("sync_load", byte_load, 1);
    check("sync_byte", byte_out, 8'h80);
    check("busy_rise", busy, 1);
    if (!hold) tx_req = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      tick;
      k++;
    end
    if (done_cnt < n) check("done_timeout", done_cnt, n);
  endtask

  task automatic compare_loads(input string tag);
    check({tag, "_nloads"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_load%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {byte_out, byte_load, fifo_rd, crc_clear, crc_enable,
                eop_out, busy, tx_done, state_dbg}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_rst  = 1'b0;
    tx_req = 1'b0;
    tx_pid = 3'd0;
    tx_len = 7'd0;
    crc16  = 16'h0000;
    for (int i = 0; i < 128; i++) fifo_mem[i] = 8'(i + 1);
    clear_stats();
    repeat (3) tick;
    check_idle_outputs("reset_outputs");
    n_rst = 1'b1;
    tick;
    check_idle_outputs("post_reset_idle");

    // ACK handshake
    clear_stats();
    send(3'd0, 7'd0, 1'b0);
    wait_done(1, 500);
    repeat (3) tick;
    exp_q = '{8'h80, 8'hD2};
    compare_loads("ack");
    check("ack_eop_len", eop_cnt, 16);
    check("ack_idlej_len", ij_cnt, 8);
    check("ack_done", done_cnt, 1);
    check("ack_fifo_rd", rd_cnt, 0);
    check("ack_crc_clear", clr_cnt, 0);

    // DATA1, 3 bytes
    clear_stats();
    fifo_mem[0] = 8'h11; fifo_mem[1] = 8'h22; fifo_mem[2] = 8'h33;
    fifo_data = fifo_mem[0];
    crc16 = 16'hBEEF;
    send(3'd4, 7'd3, 1'b0);
    wait_done(1, 1000);
    repeat (3) tick;
    exp_q = '{8'h80, 8'h4B, 8'h11, 8'h22, 8'h33, 8'hEF, 8'hBE};
    compare_loads("data1");
    check("data1_fifo_rd", rd_cnt, 3);
    check("data1_crc_en", en_cnt, 3);
    check("data1_crc_clear", clr_cnt, 1);
    check("data1_done", done_cnt, 1);

    // DATA0, zero-length
    clear_stats();
    crc16 = 16'h0000;
    send(3'd3, 7'd0, 1'b0);
    wait_done(1, 1000);
    repeat (3) tick;
    exp_q = '{8'h80, 8'hC3, 8'h00, 8'h00};
    compare_loads("zlp");
    check("zlp_fifo_rd", rd_cnt, 0);
    check("zlp_crc_clear", clr_cnt, 1);

    // Over-long request is clamped to 64 payload bytes
    for (int i = 0; i < 128; i++) fifo_mem[i] = 8'(i + 1);
    clear_stats();
    crc16 = 16'h1234;
    send(3'd3, 7'd69, 1'b0);
    wait_done(1, 2000);
    repeat (3) tick;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hC3);
    for (int i = 1; i <= 64; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    compare_loads("clamp");
    check("clamp_fifo_rd", rd_cnt, 64);
    check("clamp_crc_en", en_cnt, 64);

    // Illegal PID: dropped
    clear_stats();
    tx_pid = 3'd6;
    tx_len = 7'd2;
    tx_req = 1'b1;
    tick;
    check("illegal_busy", busy, 0);
    tx_req = 1'b0;
    repeat (20) tick;
    check("illegal_busy_cycles", busy_cnt, 0);
    check("illegal_loads", got_q.size(), 0);

    // Reset in the middle of SEND_DATA
    clear_stats();
    send(3'd3, 7'd3, 1'b0);
    begin
      int k = 0;
      while (rd_cnt < 1 && k < 200) begin
        tick;
        k++;
      end
    end
    check("abort_reached_data", rd_cnt, 1);
    repeat (3) tick;
    n_rst = 1'b0;
    #1;
    check_idle_outputs("abort_outputs");
    tick;
    n_rst = 1'b1;
    tick;
    clear_stats();
    send(3'd2, 7'd0, 1'b0);
    wait_done(1, 500);
    repeat (3) tick;
    exp_q = '{8'h80, 8'h1E};
    compare_loads("stall");
    check("stall_done", done_cnt, 1);

    // Back-to-back NAK with tx_req held, stray byte_done during EOP
    clear_stats();
    stray_en = 1'b1;
    send(3'd1, 7'd0, 1'b1);
    wait_done(1, 500);
    tick;
    check("b2b_idle_gap", busy, 0);
    tick;
    check("b2b_restart_load", byte_load, 1);
    check("b2b_restart_byte", byte_out, 8'h80);
    tx_req = 1'b0;
    wait_done(2, 500);
    repeat (3) tick;
    stray_en = 1'b0;
    exp_q = '{8'h80, 8'h5A, 8'h80, 8'h5A};
    compare_loads("b2b");
    check("b2b_eop_len", eop_cnt, 32);
    check("b2b_idlej_len", ij_cnt, 16);
    check("b2b_done", done_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_tx_sequencer.md
# usb_tx_sequencer

Parametrised USB full-speed transmit packet sequencer; the next generation of the TX controller FSM. Accepts a packet request (handshake or data), then drives SYNC, PID, payload, CRC16 and EOP through the byte shifter. Adds DATA1/STALL support, a configurable payload length with an internal byte counter, and internal EOP timing. Sits between the endpoint/FIFO logic and the bit-level shifter/NRZI encoder.

## Interface
- MAX_PAYLOAD, 64: maximum data payload bytes; LEN_W = $clog2(MAX_PAYLOAD+1)
- BIT_CYCLES, 8: clk cycles per USB bit time, ≥2
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- tx_req  in  1  start request, sampled only in IDLE
- tx_pid  in  3  0=ACK 1=NAK 2=STALL 3=DATA0 4=DATA1; 5–7 illegal
- tx_len  in  LEN_W  payload bytes for DATA0/1
- fifo_data  in  8  show-ahead FIFO head, valid the same cycle as fifo_rd
- crc16  in  16  final (complemented) CRC from the external CRC unit
- byte_done  in  1  shifter pulse: last loaded byte fully sent
- byte_out  out  8  byte to shifter, LSB sent first
- byte_load  out  1  1-cycle pulse; byte_out valid that cycle
- fifo_rd  out  1  1-cycle pop
- crc_clear  out  1  1-cycle CRC reset
- crc_enable  out  1  1-cycle: CRC absorbs byte_out
- eop_out  out  1  drive SE0
- busy  out  1  packet in progress
- tx_done  out  1  1-cycle completion pulse

## Operation
- Reset: state IDLE; all outputs 0; latched PID, length and counter 0. Reset mid-packet aborts immediately.
- Byte constants: SYNC 0x80, ACK 0xD2, NAK 0x5A, STALL 0x1E, DATA0 0xC3, DATA1 0x4B.
- IDLE: on tx_req with a legal tx_pid, latch tx_pid and min(tx_len, MAX_PAYLOAD) and go to LOAD_SYNC. Illegal tx_pid: request dropped, stays IDLE, busy stays 0.
- LOAD_SYNC: byte_load with SYNC → SEND_SYNC.
- LOAD_PID: byte_load with PID byte; crc_clear if data PID → SEND_PID.
- Every SEND_x state waits for byte_done.
- SEND_PID: handshake → EOP. Data with count > 0 → LOAD_DATA. Data with count 0 → LOAD_CRC_LO.
- LOAD_DATA: fifo_rd, byte_load and crc_enable together; byte_out = fifo_data; count decrements → SEND_DATA.
- SEND_DATA on byte_done: count ≠ 0 → LOAD_DATA, else LOAD_CRC_LO.
- LOAD_CRC_LO / LOAD_CRC_HI: byte_load crc16[7:0] then crc16[15:8], each followed by SEND_CRC_LO / SEND_CRC_HI; after SEND_CRC_HI → EOP.
- EOP: eop_out=1 for exactly 2·BIT_CYCLES clocks → IDLE_J.
- IDLE_J: eop_out=0 for BIT_CYCLES clocks → DONE.
- DONE: tx_done=1 for one cycle → IDLE.
- byte_done outside SEND_x states is ignored. tx_req while busy is ignored.

## Timing
- busy goes 1 the cycle after tx_req is accepted and stays 1 through the DONE cycle inclusive.
- First byte_load (SYNC) occurs one cycle after acceptance.
- Each LOAD state lasts exactly 1 cycle.
- byte_done → next byte_load: 1 cycle. byte_done → eop_out rise: 1 cycle.
- The CRC byte is loaded 1 cycle after the last payload byte's byte_done. The CRC unit has that cycle to settle.
- Back-to-back: tx_req may be accepted in the IDLE cycle directly after DONE.
- Data packet total = 2 + N + 2 byte loads. Handshake = 2 byte loads.

## Structure
- Package usb_tx_pkg holds:
  - pid_e enum
  - PID/SYNC byte localparams
  - state_e typedef: IDLE, LOAD_SYNC, SEND_SYNC, LOAD_PID, SEND_PID, LOAD_DATA, SEND_DATA, LOAD_CRC_LO, SEND_CRC_LO, LOAD_CRC_HI, SEND_CRC_HI, EOP, IDLE_J, DONE
- Sub-module usb_bit_timer: clear/enable counter, parameter BIT_CYCLES, outputs bit-time rollover; used for EOP and IDLE_J durations.

## Test plan
- ACK request, shifter byte_done 8 cycles after each load → byte_out 0x80, 0xD2; eop_out high 16 clk, low 8 clk; one tx_done; 0 fifo_rd.
- DATA1, tx_len=3, FIFO 0x11/0x22/0x33, crc16=0xBEEF → loads 0x80, 0x4B, 0x11, 0x22, 0x33, 0xEF, 0xBE; 3 fifo_rd; 3 crc_enable; one crc_clear.
- DATA0, tx_len=0, crc16=0x0000 → loads 0x80, 0xC3, 0x00, 0x00; no fifo_rd.
- tx_len=MAX_PAYLOAD+5 → exactly MAX_PAYLOAD fifo_rd. tx_pid=6 → no activity, busy=0.
- n_rst asserted during SEND_DATA → all outputs 0 immediately; new STALL request after release sends 0x80, 0x1E.
- tx_req held high across DONE → second packet starts in the next IDLE cycle; stray byte_done during EOP has no effect.
